// File: rtl/cdr_pi_loop_filter_if.sv
// Port bundle for the CDR PI loop filter: phase-detector vote and gain/freeze
// controls in, phase-interpolator code, update strobe and lock flag out.
interface cdr_pi_loop_filter_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 9
);
  logic signed [IN_W-1:0]  pd_vote_i;
  logic        [2:0]       kp_shift_i;
  logic        [2:0]       ki_shift_i;
  logic                    freeze_i;
  logic signed [OUT_W-1:0] out_code_o;
  logic                    upd_valid_o;
  logic                    locked_o;

  modport master (
    output pd_vote_i, kp_shift_i, ki_shift_i, freeze_i,
    input  out_code_o, upd_valid_o, locked_o
  );

  modport slave (
    input  pd_vote_i, kp_shift_i, ki_shift_i, freeze_i,
    output out_code_o, upd_valid_o, locked_o
  );
endinterface

// File: rtl/cdr_pi_loop_filter.sv
// Second-order PI loop filter with vote decimation, shift gains, holdover and lock detect.
// Define LF_FREQ_SAT_EN to saturate the frequency register instead of wrapping it.
module cdr_pi_loop_filter #(
  parameter int IN_W      = 2,
  parameter int DEC_LOG2  = 2,
  parameter int FREQ_W    = 15,
  parameter int PHASE_W   = 15,
  parameter int OUT_W     = 9,
  parameter int FREQ_FRAC = 6,
  parameter int LOCK_TH   = 2,
  parameter int LOCK_CNT  = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  cdr_pi_loop_filter_if.slave lf
);

  localparam int VS_W  = IN_W + DEC_LOG2;
  localparam int CNT_W = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;
  localparam int SUM_W = FREQ_W + 1;
  localparam int LCK_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] DEC_MAX = CNT_W'((1 << DEC_LOG2) - 1);
`ifdef LF_FREQ_SAT_EN
  localparam logic signed [FREQ_W-1:0] FREQ_MAX = {1'b0, {(FREQ_W-1){1'b1}}};
  localparam logic signed [FREQ_W-1:0] FREQ_MIN = {1'b1, {(FREQ_W-1){1'b0}}};
`endif

  logic signed [VS_W-1:0]    vote_sum_q, vote_sum_d, vote_x, win;
  logic        [CNT_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic signed [FREQ_W-1:0]  freq_q, freq_d, freq_cand, freq_shr;
  logic signed [PHASE_W-1:0] phase_q, phase_d, kp_term;
  logic signed [SUM_W-1:0]   ki_term, freq_sum, delta, delta_abs;
  logic        [LCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic signed [OUT_W-1:0]   out_code_q;
  logic                      upd_pend_q, upd_pend_d, upd_valid_q;
  logic                      win_end, quiet;

  // NOTE: every variable written here gets a default first so no path infers a latch.
  always_comb begin
    vote_x   = VS_W'(lf.pd_vote_i);
    win      = vote_sum_q + vote_x;
    win_end  = (dec_cnt_q == DEC_MAX);
    freq_shr = freq_q >>> FREQ_FRAC;
    kp_term  = PHASE_W'(win) <<< lf.kp_shift_i;
    ki_term  = SUM_W'(win) <<< lf.ki_shift_i;
    freq_sum = SUM_W'(freq_q) + ki_term;

`ifdef LF_FREQ_SAT_EN
    if (freq_sum[SUM_W-1] != freq_sum[SUM_W-2]) begin
      freq_cand = freq_sum[SUM_W-1] ? FREQ_MIN : FREQ_MAX;
    end else begin
      freq_cand = freq_sum[FREQ_W-1:0];
    end
`else
    freq_cand = FREQ_W'(freq_sum);
`endif

    vote_sum_d = win;
    dec_cnt_d  = dec_cnt_q + CNT_W'(1);
    freq_d     = freq_q;
    phase_d    = phase_q;
    upd_pend_d = 1'b0;
    lock_cnt_d = lock_cnt_q;

    if (win_end) begin
      vote_sum_d = '0;
      dec_cnt_d  = '0;
      upd_pend_d = 1'b1;
      // Holdover: a frozen update keeps freq and drops the proportional kick.
      phase_d = phase_q + PHASE_W'(freq_shr);
      if (!lf.freeze_i) begin
        freq_d  = freq_cand;
        phase_d = phase_q + PHASE_W'(freq_shr) + kp_term;
      end
    end

    delta     = SUM_W'(freq_d) - SUM_W'(freq_q);
    delta_abs = delta[SUM_W-1] ? -delta : delta;
    quiet     = (delta_abs <= SUM_W'(LOCK_TH));

    if (win_end) begin
      if (!quiet) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q != LCK_W'(LOCK_CNT)) begin
        lock_cnt_d = lock_cnt_q + LCK_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vote_sum_q  <= '0;
      dec_cnt_q   <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      lock_cnt_q  <= '0;
      upd_pend_q  <= 1'b0;
      upd_valid_q <= 1'b0;
      out_code_q  <= '0;
    end else begin
      vote_sum_q  <= vote_sum_d;
      dec_cnt_q   <= dec_cnt_d;
      freq_q      <= freq_d;
      phase_q     <= phase_d;
      lock_cnt_q  <= lock_cnt_d;
      upd_pend_q  <= upd_pend_d;
      upd_valid_q <= upd_pend_q;
      // Output stage lags the phase update by one edge.
      if (upd_pend_q) begin
        out_code_q <= phase_q[PHASE_W-1 -: OUT_W];
      end
    end
  end

  assign lf.out_code_o  = out_code_q;
  assign lf.upd_valid_o = upd_valid_q;
  assign lf.locked_o    = (lock_cnt_q == LCK_W'(LOCK_CNT));

endmodule

// File: doc/cdr_pi_loop_filter.md
Name: cdr_pi_loop_filter

Overview:
- Parametrised second-order proportional-integral (PI) loop filter for the RX CDR.
- Sits between the bang-bang phase detector vote and the phase-interpolator code.
- Adds the following over the fixed-gain filter:
  - vote decimation (windowed vote summing)
  - runtime proportional/integral shift gains
  - integrator freeze (holdover)
  - update strobe
  - lock detector
- All widths are generic.

Parameters:
- IN_W, 2, signed phase-detector vote width (-1/0/+1 encoded two's complement).
- DEC_LOG2, 2, log2 of vote decimation window (window = 2^DEC_LOG2 cycles; 0 = update every cycle).
- FREQ_W, 15, signed frequency (integral) register width.
- PHASE_W, 15, signed phase accumulator width.
- OUT_W, 9, signed output code width; out_code = phase >>> (PHASE_W-OUT_W).
- FREQ_FRAC, 6, right-shift applied to the frequency register before adding into phase.
- LOCK_TH, 2, max |freq delta| per update still counted as "quiet".
- LOCK_CNT, 16, consecutive quiet updates required to assert lock.

Ports:
- clk  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-low reset.
- pd_vote  in  IN_W  signed phase-detector vote, sampled every cycle.
- kp_shift  in  3  proportional gain; term = vote_sum <<< kp_shift.
- ki_shift  in  3  integral gain; term = vote_sum <<< ki_shift.
- freeze  in  1  holds the frequency register and discards votes while high.
- out_code  out  OUT_W  signed phase-interpolator code.
- upd_valid  out  1  one-cycle pulse when out_code takes a new value.
- locked  out  1  lock indicator.

Behaviour:
- Reset (clk edge with Reset=0) clears the following; it has priority over all other activity, including mid-window:
  - vote_sum, dec_cnt, freq, phase
  - out_code=0, upd_valid=0, locked=0
  - lock counter
- Decimation: dec_cnt increments every cycle, wrapping at 2^DEC_LOG2-1. vote_sum accumulates the sign-extended pd_vote (width IN_W+DEC_LOG2).
- Window end: the cycle with dec_cnt == max. The update uses vote_sum including that cycle's vote (win = vote_sum + pd_vote); vote_sum then restarts at 0.
- Window-end update, same edge:
  - freq_n = freq + (win <<< ki_shift), sign-extended to FREQ_W+1 before saturation/wrap.
  - phase_n = phase + (freq >>> FREQ_FRAC) + (win <<< kp_shift), using the pre-update freq. Phase wraps modulo 2^PHASE_W (rotating PI code, intentional).
- Output latency: out_code <= phase >>> (PHASE_W-OUT_W) registered on the cycle after the phase update. upd_valid pulses in that same cycle, so latency from the window-end vote to out_code is 2 edges.
- freeze=1 at a window end:
  - freq holds; win is discarded (no proportional term).
  - phase advances by freq >>> FREQ_FRAC only (holdover).
  - dec_cnt keeps running; upd_valid still pulses.
- Asserting or deasserting freeze mid-window: votes accumulated so far are kept. Only freeze at the window-end cycle decides the update.
- Lock detector, evaluated at window ends:
  - If |freq_n - freq| <= LOCK_TH (always true when frozen), the counter increments, saturating at LOCK_CNT; otherwise it clears to 0 and locked drops on the same edge.
  - locked = 1 when the counter reaches LOCK_CNT.
  - Latency: locked rises on the edge of the LOCK_CNT-th consecutive quiet update.
- Gains are sampled at the window end. Changing kp_shift/ki_shift mid-window is legal.

Optional Feature:
- Macro: LF_FREQ_SAT_EN.
- Defined: freq_n is clamped to [-(2^(FREQ_W-1)), 2^(FREQ_W-1)-1]; no wrap.
- Undefined: freq_n is truncated to FREQ_W bits (two's-complement wrap).
- Phase always wraps regardless of the macro.

Test Plan:
- Reset=0 for 3 cycles with random pd_vote -> out_code=0, upd_valid=0, locked=0. First upd_valid appears 4 cycles after reset release plus 1 (defaults).
- pd_vote=+1 constant, kp_shift=3, ki_shift=0, defaults:
  - update 1: freq=4, phase=32, out_code=0.
  - update 2: freq=8, phase=64, out_code=1.
  - upd_valid pulses every 4 cycles.
- pd_vote=+1, ki_shift=7, kp_shift=0, run 32+ updates -> freq reaches 16383 and holds with LF_FREQ_SAT_EN; without the macro, update 32 gives freq=-16384.
- Preload freq=128 via +1 votes, then freeze=1 with pd_vote=-1 -> freq stays constant, phase advances by exactly 128>>>6=2 per update, upd_valid continues.
- pd_vote alternating +1/-1 (win=0) -> locked rises at the 16th update (cycle 64 after release). One +1,+1,+1,+1 window with ki_shift=0 (delta 4 > 2) drops locked on that edge.
- Reset asserted mid-window at dec_cnt=2 -> all state zero next edge; the following window is a full 4 cycles.
